// File: rtl/bvb_pkg.sv
// Shared constants and types for the broadcast-vector-buffer section scheduler.
package bvb_pkg;

  localparam int DEF_CHANNEL_NUM  = 4;
  localparam int DEF_COL_ID_SIZE  = 10;
  localparam int DEF_COUNTER_BITS = 3;
  localparam int DEF_SECTIONS     = 8;
  localparam int DEF_ADDR_BITS    = 7;
  localparam int RAM_LATENCY      = 1;
  localparam int LANE_SHIFT       = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bvb_section_sched_picker.sv
// Round-robin section picker: first requesting section after ptr, wrapping modulo SECTIONS.
module rr_section_picker #(
  parameter int SECTIONS     = bvb_pkg::DEF_SECTIONS,
  parameter int COUNTER_BITS = bvb_pkg::DEF_COUNTER_BITS
) (
  input  logic [SECTIONS-1:0]     req_i,
  input  logic [COUNTER_BITS-1:0] ptr_i,
  output logic [COUNTER_BITS-1:0] sel_o,
  output logic                    any_o
);

  int idx;

  always_comb begin
    sel_o = '0;
    any_o = 1'b0;
    idx   = 0;
    // Search ptr+1 .. ptr so the most recently issued section has lowest priority.
    for (int i = 1; i <= SECTIONS; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= SECTIONS) idx = idx - SECTIONS;
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        sel_o = idx[COUNTER_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/bvb_section_sched.sv
// Vector-RAM section scheduler: issues one demanded section per cycle and grants matching channels.
module bvb_section_sched
  import bvb_pkg::*;
#(
  parameter int CHANNEL_NUM  = DEF_CHANNEL_NUM,
  parameter int COL_ID_SIZE  = DEF_COL_ID_SIZE,
  parameter int COUNTER_BITS = DEF_COUNTER_BITS,
  parameter int SECTIONS     = DEF_SECTIONS,
  parameter int ADDR_BITS    = DEF_ADDR_BITS
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic [ADDR_BITS-1:0]               image_base_i,
  input  logic [CHANNEL_NUM*COL_ID_SIZE-1:0] id_i,
  input  logic [CHANNEL_NUM-1:0]             id_last_i,
  input  logic [CHANNEL_NUM-1:0]             id_empty_i,
  output logic [CHANNEL_NUM-1:0]             id_read_o,
  input  logic [CHANNEL_NUM-1:0]             val_full_i,
  output logic [CHANNEL_NUM-1:0]             val_wr_en_o,
  output logic [CHANNEL_NUM*COL_ID_SIZE-1:0] lane_off_o,
  output logic [ADDR_BITS-1:0]               ram_addr_o,
  output logic                               ram_rd_en_o,
  output logic                               busy_o,
  output logic                               image_done_o,
  output logic                               sec_err_o
);

  typedef logic [CHANNEL_NUM-1:0][COL_ID_SIZE-1:0] id_vec_t;

  localparam logic [COUNTER_BITS:0] SEC_LIM = (COUNTER_BITS + 1)'(SECTIONS);

  state_e                  state_q, state_d;
  logic                    sweep;
  logic [ADDR_BITS-1:0]    base_q;
  logic [COUNTER_BITS-1:0] ptr_q, sel;
  logic                    any;
  logic [CHANNEL_NUM-1:0]  fin_q, val_wr_en_q, eligible, grant, bad;
  logic [SECTIONS-1:0]     req;
  logic [COUNTER_BITS-1:0] head_sec [CHANNEL_NUM];
  logic                    live, in_range;
  logic                    sec_err_q;
  id_vec_t                 id_v, lane_off_q;

  assign id_v = id_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req      = '0;
    eligible = '0;
    bad      = '0;
    live     = 1'b0;
    in_range = 1'b0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      head_sec[c] = id_v[c][COL_ID_SIZE-1 -: COUNTER_BITS];
      in_range    = {1'b0, head_sec[c]} < SEC_LIM;
      live        = sweep && !id_empty_i[c] && !fin_q[c];
      // pend (last cycle's val_wr_en) keeps a channel out until its val_full reflects that write.
      eligible[c] = live && in_range && !val_full_i[c] && !val_wr_en_q[c];
      bad[c]      = live && !in_range;
      if (eligible[c]) req[head_sec[c]] = 1'b1;
    end
  end

  rr_section_picker #(
    .SECTIONS     (SECTIONS),
    .COUNTER_BITS (COUNTER_BITS)
  ) u_picker (
    .req_i (req),
    .ptr_i (ptr_q),
    .sel_o (sel),
    .any_o (any)
  );

  always_comb begin
    grant = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      grant[c] = eligible[c] && (head_sec[c] == sel);
    end
  end

  assign id_read_o   = grant;
  assign ram_rd_en_o = any;
  assign ram_addr_o  = any ? base_q + ADDR_BITS'(sel) : '0;
  assign val_wr_en_o = val_wr_en_q;
  assign lane_off_o  = lane_off_q;
  assign sec_err_o   = sec_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SWEEP;
      ST_SWEEP: if (&fin_q)  state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sweep        = (state_q == ST_SWEEP);
    busy_o       = (state_q != ST_IDLE);
    image_done_o = (state_q == ST_DONE);
  end

  // Grant results land one cycle later to line up with the RAM_LATENCY-cycle read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q      <= '0;
      ptr_q       <= COUNTER_BITS'(SECTIONS - 1);
      fin_q       <= '0;
      val_wr_en_q <= '0;
      lane_off_q  <= '0;
      sec_err_q   <= 1'b0;
    end else begin
      val_wr_en_q <= grant;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        if (grant[c]) lane_off_q[c] <= id_v[c] << LANE_SHIFT;
      end
      if (any) ptr_q <= sel;
      if (state_q == ST_IDLE && start_i) begin
        base_q <= image_base_i;
        fin_q  <= '0;
      end else begin
        fin_q <= fin_q | (grant & id_last_i);
      end
      if (|bad) sec_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bvb_section_sched.sv
// Directed bench for bvb_section_sched: default instance plus a SECTIONS=6 instance for range errors.
module tb_bvb_section_sched;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [6:0]       image_base;
  logic [3:0][9:0]  id;
  logic [3:0]       id_last, id_empty, val_full;
  logic [3:0]       id_read, val_wr_en;
  logic [3:0][9:0]  lane_off;
  logic [6:0]       ram_addr;
  logic             ram_rd_en, busy, image_done, sec_err;

  logic             rst6_n, start6;
  logic [6:0]       base6;
  logic [3:0][9:0]  id6;
  logic [3:0]       last6, empty6, full6;
  logic [3:0]       id_read6, val_wr_en6;
  logic [3:0][9:0]  lane_off6;
  logic [6:0]       ram_addr6;
  logic             ram_rd_en6, busy6, done6, sec_err6;

  int n_cmp = 0;
  int n_bad = 0;
  int pops0, pops1, wr1;

  always #5 clk = ~clk;

  bvb_section_sched dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .image_base_i(image_base),
    .id_i(id), .id_last_i(id_last), .id_empty_i(id_empty), .id_read_o(id_read),
    .val_full_i(val_full), .val_wr_en_o(val_wr_en), .lane_off_o(lane_off),
    .ram_addr_o(ram_addr), .ram_rd_en_o(ram_rd_en), .busy_o(busy),
    .image_done_o(image_done), .sec_err_o(sec_err)
  );

  bvb_section_sched #(.SECTIONS(6)) dut6 (
    .clk_i(clk), .rst_ni(rst6_n), .start_i(start6), .image_base_i(base6),
    .id_i(id6), .id_last_i(last6), .id_empty_i(empty6), .id_read_o(id_read6),
    .val_full_i(full6), .val_wr_en_o(val_wr_en6), .lane_off_o(lane_off6),
    .ram_addr_o(ram_addr6), .ram_rd_en_o(ram_rd_en6), .busy_o(busy6),
    .image_done_o(done6), .sec_err_o(sec_err6)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_image(input logic [6:0] base);
    start      = 1'b1;
    image_base = base;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    id_empty = 4'hF;
    #1;
    while (image_done !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check({tag, "_done"}, image_done, 1);
    tick();
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; image_base = '0; id = '0;
    id_last = '0; id_empty = 4'hF; val_full = '0;
    rst6_n = 1'b0; start6 = 1'b0; base6 = '0; id6 = '0;
    last6 = '0; empty6 = 4'hF; full6 = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_outs", {id_read, val_wr_en, ram_rd_en, image_done, sec_err}, 0);
    check("rst_addr_lane", {ram_addr, lane_off}, 0);
    rst_n = 1'b1; rst6_n = 1'b1;
    tick();

    // Two sections for ch0 at base 5; ch1-3 finish in section 0 alongside it.
    start_image(7'd5);
    check("t2_busy", busy, 1);
    id = {10'h040, 10'h030, 10'h020, 10'h010};
    id_last = 4'b1110; id_empty = 4'b0000;
    #1;
    check("t2_sec0_rd", id_read, 4'b1111);
    check("t2_sec0_addr", ram_addr, 5);
    tick();
    id[0] = 10'h3F0; id_last = 4'b1111; id_empty = 4'b1110;
    #1;
    check("t2_wr", val_wr_en, 4'b1111);
    check("t2_lane", lane_off, {10'h200, 10'h180, 10'h100, 10'h080});
    check("t2_pend", {id_read, ram_rd_en}, 0);
    tick();
    check("t2_sec7_rd", id_read, 4'b0001);
    check("t2_sec7_addr", ram_addr, 12);
    tick();
    id_empty = 4'hF;
    #1;
    check("t2_wr7", val_wr_en, 4'b0001);
    check("t2_lane7", lane_off[0], 10'h380);
    wait_done("t2");

    // All four channels in section 3, base wraps past the top of the address space.
    start_image(7'h7E);
    id = {10'h1FF, 10'h1A0, 10'h190, 10'h180};
    id_last = 4'b1111; id_empty = 4'b0000;
    #1;
    check("t3_rd", id_read, 4'b1111);
    check("t3_addr", ram_addr, 7'h01);
    tick();
    id_empty = 4'hF;
    #1;
    check("t3_wr", val_wr_en, 4'b1111);
    check("t3_lane", lane_off, {10'h3F8, 10'h100, 10'h080, 10'h000});
    wait_done("t3");

    // Round-robin: ptr lands on 2, then sec2 and sec6 compete.
    start_image(7'd0);
    id[0] = 10'h100; id_last = 4'b0000; id_empty = 4'b1110;
    #1;
    check("t4_prime_addr", {ram_rd_en, ram_addr}, {1'b1, 7'd2});
    tick();
    id[0] = 10'h110; id[1] = 10'h140; id[2] = 10'h300;
    id_last = 4'b0111; id_empty = 4'b1000;
    #1;
    check("t4_sec6_addr", ram_addr, 6);
    check("t4_sec6_rd", id_read, 4'b0100);
    tick();
    id_empty = 4'b1100;
    #1;
    check("t4_sec2_addr", ram_addr, 2);
    check("t4_sec2_rd", id_read, 4'b0011);
    check("t4_sec2_wr", val_wr_en, 4'b0100);
    tick();
    id[3] = 10'h000; id_last = 4'b1111; id_empty = 4'b0111;
    #1;
    check("t4_sec0_rd", {id_read, ram_addr}, {4'b1000, 7'd0});
    check("t4_sec0_wr", val_wr_en, 4'b0011);
    tick();
    wait_done("t4");

    // ch1 blocked by val_full for 10 cycles while ch0/ch2 keep flowing.
    start_image(7'd0);
    id = {10'h000, 10'h040, 10'h080, 10'h000};
    id_last = 4'b0000; id_empty = 4'b1000; val_full = 4'b0010;
    pops0 = 0; pops1 = 0; wr1 = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      pops0 += int'(id_read[0]);
      pops1 += int'(id_read[1]);
      wr1   += int'(val_wr_en[1]);
      tick();
    end
    check("t5_ch0_pops", pops0, 5);
    check("t5_ch1_pops", pops1 + wr1, 0);
    val_full = 4'b0000; id[3] = 10'h050; id_last = 4'b1111; id_empty = 4'b0000;
    #1;
    check("t5_release", {id_read, ram_addr}, {4'b0010, 7'd1});
    tick();
    id_empty = 4'b0010;
    #1;
    check("t5_rest", id_read, 4'b1101);
    check("t5_wr1", val_wr_en, 4'b0010);
    tick();
    wait_done("t5");

    // Reset with grants in flight, then a fresh image must restart the pointer.
    start_image(7'd0);
    id = {10'h003, 10'h002, 10'h001, 10'h004};
    id_last = 4'b0000; id_empty = 4'b0000;
    #1;
    check("t1_rd", id_read, 4'b1111);
    tick();
    check("t1_inflight", val_wr_en, 4'b1111);
    rst_n = 1'b0;
    #1;
    check("t1_rst_outs", {id_read, val_wr_en, ram_rd_en, busy, image_done}, 0);
    check("t1_rst_addr_lane", {ram_addr, lane_off}, 0);
    id_empty = 4'hF;
    #1;
    rst_n = 1'b1;
    tick();
    start_image(7'h30);
    id = {10'h000, 10'h000, 10'h000, 10'h080};
    id_last = 4'b1111; id_empty = 4'b0000;
    #1;
    check("t1_fresh_rd", id_read, 4'b1110);
    check("t1_fresh_addr", ram_addr, 7'h30);
    tick();
    id_empty = 4'b1110;
    #1;
    check("t1_sec1", {id_read, ram_addr}, {4'b0001, 7'h31});
    tick();
    wait_done("t1");

    // SECTIONS=6 instance: out-of-range head, ignored start while busy.
    start6 = 1'b1; base6 = 7'h20;
    tick();
    start6 = 1'b0;
    id6[0] = 10'h3C0; empty6 = 4'b1110;
    #1;
    check("t6_no_rd", {id_read6, ram_rd_en6}, 0);
    tick();
    check("t6_err", sec_err6, 1);
    check("t6_stall", id_read6, 0);
    start6 = 1'b1; base6 = 7'h40;
    tick();
    start6 = 1'b0;
    id6[1] = 10'h100; empty6 = 4'b1101;
    #1;
    check("t6_busy", busy6, 1);
    check("t6_rd", id_read6, 4'b0010);
    check("t6_base_kept", ram_addr6, 7'h22);
    check("t6_sticky", sec_err6, 1);
    tick();
    rst6_n = 1'b0;
    #1;
    check("t6_rst", {sec_err6, busy6}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
